decode: RTL and testbench
=========================

Name: decode

Overview:
- Decode stage of the single-cycle (SEQ) Y86-64 processor; contains the architectural register file (15 x 64-bit, IDs 0..14).
- Selects source registers srcA/srcB from icode, rA and rB, and drives their contents on valA/valB for execute and memory.
- Also provides the write-back write ports (dstE/valE, dstM/valM) so the stage owns the entire register file.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- icode  input  4  instruction code from fetch
- rA  input  4  register A specifier (4'hF = none)
- rB  input  4  register B specifier (4'hF = none)
- dstE  input  4  write-back E destination (4'hF = no write)
- valE  input  64  write-back E data
- dstM  input  4  write-back M destination (4'hF = no write)
- valM  input  64  write-back M data
- valA  output  64  contents of srcA, or 0 when srcA = none
- valB  output  64  contents of srcB, or 0 when srcB = none

Behaviour:
- Register IDs: 0 rax, 1 rcx, 2 rdx, 3 rbx, 4 rsp, 5 rbp, 6 rsi, 7 rdi, 8..14 r8..r14; 15 = none.
- srcA (combinational):
  - rA for icode 2 (cmovXX), 4 (rmmovq), 6 (OPq), 10 (pushq)
  - 4 (rsp) for icode 9 (ret), 11 (popq)
  - otherwise 15
- srcB (combinational):
  - rB for icode 4, 5 (mrmovq), 6
  - 4 (rsp) for icode 8 (call), 9, 10, 11
  - otherwise 15
- Reads are combinational, zero latency. valA/valB follow icode/rA/rB and register contents with no clock.
- A source of 15 reads as 64'd0. This covers icode 0, 1, 3, 7 and undefined icodes 12..15.
- Writes occur on the rising edge of clk when reset = 0:
  - reg[dstE] <= valE if dstE != 15
  - reg[dstM] <= valM if dstM != 15
  - if dstE == dstM != 15, valM wins
- Write-then-read: a register written on an edge is visible on valA/valB immediately after that edge. There is no same-cycle bypass before the edge.
- Reset: on a rising edge with reset = 1, reg[i] <= i (64-bit zero-extended) for i = 0..14. Reset overrides any simultaneous write.
- valA/valB are combinational and have no reset value of their own. After reset they reflect the reset contents (e.g. rsp = 4).
- Unknown (X) or 15 in dstE/dstM performs no write. The write guard must treat a non-true compare as no write.
- No other state; no handshake; one instruction per cycle.

Test Plan:
- Reset, then icode=2, rA=0, rB=1 -> valA=0 (rax), valB=0 (srcB none).
- icode=4, rA=1, rB=2 -> valA=1, valB=2. icode=6, rA=1, rB=3 -> valA=1, valB=3. icode=5, rA=0, rB=3 -> valA=0, valB=3.
- icode=8, rA=8, rB=0 -> valA=0, valB=4. icode=9, rA=9, rB=10 -> valA=4, valB=4. icode=11, rA=9, rB=1 -> valA=4, valB=4. icode=10, rA=2, rB=0 -> valA=2, valB=4.
- icode=3, rA=2, rB=8 -> valA=0, valB=0. icode=0 and icode=7 -> both outputs 0.
- dstE=2, valE=64'hDEAD_BEEF, dstM=15 on an edge; then icode=6, rA=2, rB=2 -> valA=valB=64'hDEAD_BEEF. dstE=dstM=5, valE=1, valM=7 -> rbp reads 7.
- Write rbx=99, then assert reset for one edge together with dstE=3, valE=5 -> rbx reads 3 (reset wins).

Source files
------------

// File: rtl/decode.sv
// Y86-64 SEQ decode stage: owns the 15-entry architectural register file,
// selects srcA/srcB from the instruction and reads them combinationally.
module decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [3:0]  dstE,
   input  logic [63:0] valE,
   input  logic [3:0]  dstM,
   input  logic [63:0] valM,
   output logic [63:0] valA,
   output logic [63:0] valB
);

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] REG_RSP  = 4'h4;

   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [63:0] regs_q [15];
   logic [3:0]  src_a;
   logic [3:0]  src_b;

   always_comb begin
      src_a = REG_NONE;
      case (icode)
         I_CMOVXX, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
         I_RET, I_POPQ:                      src_a = REG_RSP;
         default:                            src_a = REG_NONE;
      endcase
   end

   always_comb begin
      src_b = REG_NONE;
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = REG_RSP;
         default:                            src_b = REG_NONE;
      endcase
   end

   // An rA/rB of 15 under cmov/OPq etc. also lands here and reads as zero.
   always_comb begin
      valA = 64'd0;
      valB = 64'd0;
      if (src_a != REG_NONE) valA = regs_q[src_a];
      if (src_b != REG_NONE) valB = regs_q[src_b];
   end

   // The M port is applied after E so it wins when both target one register.
   // Guards use positive compares so an unknown destination writes nothing.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 15; i++) regs_q[i] <= 64'(i);
      end else begin
         if (dstE != REG_NONE) regs_q[dstE] <= valE;
         if (dstM != REG_NONE) regs_q[dstM] <= valM;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: driver pushes expected valA/valB from a
// register-array model, monitor pops and compares once inputs have settled.
module tb_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  icode, rA, rB, dstE, dstM;
   logic [63:0] valE, valM, valA, valB;

   decode dut (
      .clk   (clk),
      .reset (reset),
      .icode (icode),
      .rA    (rA),
      .rB    (rB),
      .dstE  (dstE),
      .valE  (valE),
      .dstM  (dstM),
      .valM  (valM),
      .valA  (valA),
      .valB  (valB)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] model [15];
   int          tests  = 0;
   int          errors = 0;
   event        mon_ev;

   function automatic logic [63:0] model_read(input logic [3:0] r);
      if (r == 4'hF) return 64'd0;
      return model[r];
   endfunction

   // Architectural reading of which register each instruction consumes.
   function automatic logic [63:0] ref_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return model_read(ra);
      if (ic inside {4'd9, 4'd11})             return model[4];
      return 64'd0;
   endfunction

   function automatic logic [63:0] ref_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'd4, 4'd5, 4'd6})          return model_read(rb);
      if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return model[4];
      return 64'd0;
   endfunction

   // One instruction per cycle: drive at negedge, expect, then update model at posedge.
   task automatic step(input string nm, input logic rst, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input bit chk, input bit use_k,
                       input logic [63:0] ka, input logic [63:0] kb);
      exp_t e;
      @(negedge clk);
      reset = rst; icode = ic; rA = ra; rB = rb;
      dstE = de; valE = ve; dstM = dm; valM = vm;
      if (chk) begin
         e.name = nm;
         e.a = use_k ? ka : ref_a(ic, ra);
         e.b = use_k ? kb : ref_b(ic, rb);
         sb_q.push_back(e);
         ->mon_ev;
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 15; i++) model[i] = 64'(i);
      end else begin
         if (de != 4'hF) model[de] = ve;
         if (dm != 4'hF) model[dm] = vm;
      end
   endtask

   task automatic rd(input string nm, input logic [3:0] ic, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] ka, input logic [63:0] kb);
      step(nm, 1'b0, ic, ra, rb, 4'hF, 64'd0, 4'hF, 64'd0, 1'b1, 1'b1, ka, kb);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(mon_ev);
         #1;
         if (sb_q.size() == 0) begin
            tests++; errors++;
            $display("FAIL %s: scoreboard empty when output presented", "monitor");
         end else begin
            e = sb_q.pop_front();
            tests++;
            if (valA !== e.a) begin
               errors++;
               $display("FAIL %s valA: got %h expected %h", e.name, valA, e.a);
            end
            tests++;
            if (valB !== e.b) begin
               errors++;
               $display("FAIL %s valB: got %h expected %h", e.name, valB, e.b);
            end
         end
      end
   end

   initial begin : driver
      logic [3:0]  ic, ra, rb, de, dm;
      logic [63:0] ve, vm;
      logic        rst;
      int          budget;
      reset = 1'b0; icode = 4'd0; rA = 4'hF; rB = 4'hF;
      dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0;
      for (int i = 0; i < 15; i++) model[i] = 'x;

      step("reset", 1'b1, 4'd0, 4'hF, 4'hF, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 1'b0, 0, 0);

      rd("cmov",   4'd2,  4'd0, 4'd1,  64'd0, 64'd0);
      rd("rmmov",  4'd4,  4'd1, 4'd2,  64'd1, 64'd2);
      rd("opq",    4'd6,  4'd1, 4'd3,  64'd1, 64'd3);
      rd("mrmov",  4'd5,  4'd0, 4'd3,  64'd0, 64'd3);
      rd("call",   4'd8,  4'd8, 4'd0,  64'd0, 64'd4);
      rd("ret",    4'd9,  4'd9, 4'd10, 64'd4, 64'd4);
      rd("popq",   4'd11, 4'd9, 4'd1,  64'd4, 64'd4);
      rd("pushq",  4'd10, 4'd2, 4'd0,  64'd2, 64'd4);
      rd("irmov",  4'd3,  4'd2, 4'd8,  64'd0, 64'd0);
      rd("halt",   4'd0,  4'd2, 4'd8,  64'd0, 64'd0);
      rd("jxx",    4'd7,  4'd2, 4'd8,  64'd0, 64'd0);
      rd("undef",  4'd13, 4'd2, 4'd8,  64'd0, 64'd0);
      rd("opq_f",  4'd6,  4'hF, 4'hF,  64'd0, 64'd0);

      step("wr_e", 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 64'hDEAD_BEEF, 4'hF, 64'd0, 1'b1, 1'b1, 0, 0);
      rd("rd_rdx", 4'd6, 4'd2, 4'd2, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
      step("wr_em", 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 64'd1, 4'd5, 64'd7, 1'b1, 1'b1, 0, 0);
      rd("m_wins", 4'd6, 4'd5, 4'd5, 64'd7, 64'd7);
      step("nobyp", 1'b0, 4'd6, 4'd1, 4'd1, 4'd1, 64'd77, 4'hF, 64'd0, 1'b1, 1'b1, 64'd1, 64'd1);
      rd("after",  4'd6, 4'd1, 4'd1, 64'd77, 64'd77);
      step("wr_rbx", 1'b0, 4'd0, 4'd0, 4'd0, 4'd3, 64'd99, 4'hF, 64'd0, 1'b1, 1'b1, 0, 0);
      step("rst_wr", 1'b1, 4'd6, 4'd3, 4'd3, 4'd3, 64'd5, 4'hF, 64'd0, 1'b1, 1'b1, 64'd99, 64'd99);
      rd("rst_win", 4'd6, 4'd3, 4'd3, 64'd3, 64'd3);
      rd("rsp_rst", 4'd10, 4'd1, 4'd0, 64'd1, 64'd4);

      for (int n = 0; n < 400; n++) begin
         ic  = 4'($urandom_range(0, 15));
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         de  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         dm  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) dm = de;
         ve  = {$urandom, $urandom};
         vm  = {$urandom, $urandom};
         rst = ($urandom_range(0, 49) == 0);
         step("rand", rst, ic, ra, rb, de, ve, dm, vm, 1'b1, 1'b0, 0, 0);
      end

      budget = 0;
      while (sb_q.size() != 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (sb_q.size() != 0) begin
         tests++; errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
